led7seg_595_scan_driver: RTL
============================

Name: led7seg_595_scan_driver

Overview:
Downstream display stage for the timer datapath. It accepts a packed 8-digit x 8-segment pattern word with a valid strobe and holds it in a shadow register. It continuously multiplexes the digits by serialising one {segment, digit-select} word per digit into a daisy-chained 74HC595 pair via sclk/dio. It then pulses rclk to latch each word onto the display outputs.

Parameters:
DIG_NUM, 8, number of digits scanned per frame
SEG_NUM, 8, segment bits per digit, passed through unmodified
DIV_WIDTH, 8, tick divider width; one phase = 2^DIV_WIDTH clk cycles
DIG_ACTIVE_LOW, 0, 1 = digit-select bits inverted (one-cold)

Ports:
clk  in  1  system clock (125 MHz nominal)
rst  in  1  reset, asynchronous, active-high
dat  in  SEG_NUM*DIG_NUM  packed segment patterns; digit i = dat[SEG_NUM*i +: SEG_NUM], digit 0 rightmost
vld  in  1  dat qualifier, sampled every clk
sclk  out  1  595 shift clock
rclk  out  1  595 storage-register latch
dio  out  1  595 serial data
frame_done  out  1  one-clk pulse after the last digit of a frame is latched

Behaviour:
- Reset (async): sclk=0, rclk=0, dio=0, frame_done=0, shadow=0, active=0, digit index=0, divider=0, state=IDLE. All outputs are registered.
- Shadow capture: any clk with vld=1 loads the shadow from dat. The shadow holds otherwise.
- IDLE: stays in IDLE with no sclk/rclk activity until the first vld. On the cycle after the first vld, load active from shadow and go to LOAD.
- Tick: the divider free-runs while not in IDLE. A tick occurs when the divider wraps, every 2^DIV_WIDTH clk. Each state below lasts exactly one tick.
- LOAD: build W = {active[digit], sel}, width CHA_WIDTH = SEG_NUM+DIG_NUM. sel = 1<<digit, inverted if DIG_ACTIVE_LOW. Set bit counter to CHA_WIDTH-1, then go to SHIFT_LO.
- SHIFT_LO: sclk=0, dio=W[bit]. Bits go out MSB first, so segment MSB is first on the wire. Next state is SHIFT_HI.
- SHIFT_HI: sclk=1 (the 595 samples dio on this rising edge); dio is held. If bit==0, go to LATCH_HI; otherwise bit-- and go to SHIFT_LO.
- LATCH_HI: sclk=0, rclk=1. Next state is LATCH_LO.
- LATCH_LO: rclk=0.
  - If digit==DIG_NUM-1: assert frame_done for one clk, set digit=0, reload active from shadow, go to LOAD.
  - Otherwise: digit++, go to LOAD.
- Per-digit cost is 1 + 2*CHA_WIDTH + 2 ticks = 35 ticks. Frame cost is DIG_NUM*35 ticks.
- Tearing rule: active changes only at frame boundaries. A vld mid-frame affects only the next frame.
- Simultaneous vld and frame reload (same clk): the new dat is bypassed into active.
- Scanning never stops once started; vld=0 simply keeps the last pattern.
- Reset mid-operation: outputs go to 0 immediately. The driver then waits in IDLE for a new vld.
- dio changes only while sclk=0. rclk is never high while sclk=1.

Decomposition:
- Shared package: CHA_WIDTH and DAT_WIDTH localparam formulas, and the state enum {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH_HI, LATCH_LO}. The timer top reuses the DAT_WIDTH formula.
- One sub-module: led7seg_tick_gen (DIV_WIDTH-bit free-running divider with enable), producing a one-clk tick pulse.
- All other logic (shadow, active, FSM, shifter) stays in the top block.

Test Plan:
(All scenarios use DIV_WIDTH=2, so one tick = 4 clk.)
1. Reset, vld=0 for 2000 clk -> sclk, rclk, dio and frame_done stay 0 throughout.
2. dat=64'h0123456789ABCDEF, single-cycle vld -> first word on the sclk rising edges is 16'hEF01, MSB first. sclk period is 8 clk. rclk is high for 4 clk after the 16th bit, with sclk=0.
3. Continue from scenario 2 -> words EF01, CD02, AB04, 8908, 6710, 4520, 2340, 0180 in order. frame_done pulses once every 8*35*4 = 1120 clk, then digit 0 repeats.
4. Mid-frame (during digit 3), vld with dat=64'hFFFF…FF -> digits 3–7 still show the old patterns. The next frame shows FF segment bytes on all digits.
5. Async rst asserted during SHIFT_HI -> sclk, rclk and dio are 0 immediately. No activity follows until a new vld, and scanning then restarts at digit 0.
6. DIG_ACTIVE_LOW=1 with the scenario 2 data -> first word is 16'hEFFE, and the digit 7 word is 16'h017F.

Source files
------------

// File: rtl/led7seg_595_scan_driver_pkg.sv
// Shared definitions for the 74HC595 seven-segment scan driver.
// The width helpers are also used by the timer top to size its pattern bus.
package led7seg_595_scan_driver_pkg;

    // Scan FSM states; each non-IDLE state lasts exactly one divider tick.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH_HI = 3'd4,
        LATCH_LO = 3'd5
    } scan_state_e;

    // Bits shifted per digit: segment byte followed by the digit-select field.
    function automatic int cha_width(input int seg_num, input int dig_num);
        return seg_num + dig_num;
    endfunction

    // Width of the packed pattern word covering every digit.
    function automatic int dat_width(input int seg_num, input int dig_num);
        return seg_num * dig_num;
    endfunction

endpackage

// File: rtl/led7seg_595_scan_driver_tick_gen.sv
// Free-running phase divider: one-clk tick every 2^DIV_WIDTH cycles while enabled.
// Holding it cleared while disabled makes the first phase after start full length.
module led7seg_tick_gen #(
    parameter int DIV_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;

    // Count while enabled, otherwise park at zero.
    always_comb begin
        div_d = '0;
        if (en) begin
            div_d = div_q + DIV_WIDTH'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Tick on the cycle the divider is about to wrap.
    assign tick = en & (&div_q);

endmodule

// File: rtl/led7seg_595_scan_driver.sv
// Multiplexed 7-segment driver feeding a daisy-chained 74HC595 pair.
// A shadow register takes every valid pattern; the active copy used for
// scanning is refreshed only at frame boundaries so a frame never tears.
// Each digit is sent MSB first as {segments, digit-select}, then latched by rclk.
// sclk, rclk, dio and frame_done are all driven straight from flops; dio
// only moves on the same edge that drops sclk, and rclk rises only with sclk low.
module led7seg_595_scan_driver
    import led7seg_595_scan_driver_pkg::*;
#(
    parameter int DIG_NUM        = 8,
    parameter int SEG_NUM        = 8,
    parameter int DIV_WIDTH      = 8,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [dat_width(SEG_NUM, DIG_NUM)-1:0]   dat,
    input  logic                                     vld,
    output logic                                     sclk,
    output logic                                     rclk,
    output logic                                     dio,
    output logic                                     frame_done
);

    localparam int DAT_WIDTH = dat_width(SEG_NUM, DIG_NUM);
    localparam int CHA_WIDTH = cha_width(SEG_NUM, DIG_NUM);
    localparam int DIG_W     = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
    localparam int BIT_W     = (CHA_WIDTH > 1) ? $clog2(CHA_WIDTH) : 1;

    scan_state_e            state_q, state_d;
    logic [DAT_WIDTH-1:0]   shadow_q, shadow_d;
    logic [DAT_WIDTH-1:0]   active_q, active_d;
    logic [DIG_W-1:0]       digit_q, digit_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [CHA_WIDTH-1:0]   word_q, word_d;
    logic                   sclk_q, sclk_d;
    logic                   rclk_q, rclk_d;
    logic                   dio_q, dio_d;
    logic                   frame_done_q, frame_done_d;

    logic                   tick;
    logic [SEG_NUM-1:0]     seg_cur;
    logic [DIG_NUM-1:0]     sel_cur;
    logic [CHA_WIDTH-1:0]   word_cur;

    led7seg_tick_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    // Build the serial word for the digit currently being scanned.
    always_comb begin
        seg_cur = '0;
        for (int i = 0; i < DIG_NUM; i++) begin
            if (digit_q == DIG_W'(i)) begin
                seg_cur = active_q[SEG_NUM*i +: SEG_NUM];
            end
        end
        sel_cur          = '0;
        sel_cur[digit_q] = 1'b1;
        if (DIG_ACTIVE_LOW) begin
            sel_cur = ~sel_cur;
        end
        word_cur = {seg_cur, sel_cur};
    end

    // Next-state and registered-output logic of the scan FSM.
    always_comb begin
        shadow_d     = vld ? dat : shadow_q;
        state_d      = state_q;
        active_d     = active_q;
        digit_d      = digit_q;
        bit_d        = bit_q;
        word_d       = word_q;
        sclk_d       = sclk_q;
        rclk_d       = rclk_q;
        dio_d        = dio_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (vld) begin
                    active_d = dat;
                    digit_d  = '0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (tick) begin
                    word_d  = word_cur;
                    bit_d   = BIT_W'(CHA_WIDTH - 1);
                    sclk_d  = 1'b0;
                    dio_d   = word_cur[CHA_WIDTH-1];
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    if (bit_q == '0) begin
                        rclk_d  = 1'b1;
                        state_d = LATCH_HI;
                    end else begin
                        bit_d   = bit_q - BIT_W'(1);
                        dio_d   = word_q[bit_d];
                        state_d = SHIFT_LO;
                    end
                end
            end
            LATCH_HI: begin
                if (tick) begin
                    rclk_d  = 1'b0;
                    state_d = LATCH_LO;
                end
            end
            LATCH_LO: begin
                if (tick) begin
                    if (digit_q == DIG_W'(DIG_NUM - 1)) begin
                        frame_done_d = 1'b1;
                        digit_d      = '0;
                        // shadow_d already carries a same-cycle vld bypass
                        active_d     = shadow_d;
                    end else begin
                        digit_d = digit_q + DIG_W'(1);
                    end
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            active_q     <= '0;
            digit_q      <= '0;
            bit_q        <= '0;
            word_q       <= '0;
            sclk_q       <= 1'b0;
            rclk_q       <= 1'b0;
            dio_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            digit_q      <= digit_d;
            bit_q        <= bit_d;
            word_q       <= word_d;
            sclk_q       <= sclk_d;
            rclk_q       <= rclk_d;
            dio_q        <= dio_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sclk       = sclk_q;
    assign rclk       = rclk_q;
    assign dio        = dio_q;
    assign frame_done = frame_done_q;

endmodule
